// File: rtl/sa_drain_ctrl.sv
// sa_drain_ctrl: drains one 16-lane systolic-array result batch at a time
// into the output-memory write port, one write per valid lane at consecutive
// addresses, until the programmed conv count is used up.
// Optional build macro SA_DRAIN_RELU_EN: when defined, written data is
// ReLU-clamped (negative signed lane values written as zero).
// All outputs are registers loaded from next-state values, so no input has a
// combinational path to an output.
module sa_drain_ctrl #(
   parameter int LANES = 16,
   parameter int DW    = 16,
   parameter int AW    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [15:0]           total_convs,
   input  logic                  res_valid,
   input  logic [LANES*DW-1:0]   res_data,
   output logic                  res_ready,
   output logic                  mem_req,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_data,
   input  logic                  mem_gnt,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(LANES + 1);   // holds 0..LANES
   localparam int IW = $clog2(LANES);       // lane index into the shadow

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [AW-1:0]        addr_r, addr_s;
   logic [15:0]          rem_r, rem_s;
   logic [CW-1:0]        bcnt_r, bcnt_s;
   logic [CW-1:0]        lane_r, lane_s;
   logic [LANES*DW-1:0]  shadow_r, shadow_s;
   logic [IW-1:0]        lane_sel_s;
   logic [DW-1:0]        data_s;

   // Output data shaping: optional ReLU on the signed lane value
   function automatic logic [DW-1:0] shape_f(input logic [DW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
      if (v[DW-1]) begin
         return {DW{1'b0}};
      end else begin
         return v;
      end
`else
      return v;
`endif
   endfunction

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath update logic
   always_comb begin
      state_s  = state_r;
      addr_s   = addr_r;
      rem_s    = rem_r;
      bcnt_s   = bcnt_r;
      lane_s   = lane_r;
      shadow_s = shadow_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               addr_s = base_addr;
               rem_s  = total_convs;
               lane_s = {CW{1'b0}};
               if (total_convs == 16'd0) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_WAIT;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (res_valid && res_ready) begin
               shadow_s = res_data;
               lane_s   = {CW{1'b0}};
               if (rem_r < 16'(LANES)) begin
                  bcnt_s = rem_r[CW-1:0];
               end else begin
                  bcnt_s = CW'(LANES);
               end
               state_s = S_DRAIN;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_DRAIN: begin
            if (mem_gnt) begin
               lane_s = lane_r + CW'(1);
               addr_s = addr_r + AW'(1);
               rem_s  = rem_r - 16'd1;
               if (lane_r == (bcnt_r - CW'(1))) begin
                  if (rem_r != 16'd1) begin
                     state_s = S_WAIT;
                  end else begin
                     state_s = S_DONE;
                  end
               end else begin
                  state_s = S_DRAIN;
               end
            end else begin
               state_s = S_DRAIN;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Select the lane that will be presented next; the index wraps harmlessly
   // once a full batch has been consumed because mem_req is low then
   always_comb begin
      lane_sel_s = lane_s[IW-1:0];
      data_s     = shape_f(shadow_s[32'(lane_sel_s) * DW +: DW]);
   end

   // Datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r    <= {AW{1'b0}};
         rem_r     <= 16'd0;
         bcnt_r    <= {CW{1'b0}};
         lane_r    <= {CW{1'b0}};
         shadow_r  <= {(LANES*DW){1'b0}};
         res_ready <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= {AW{1'b0}};
         mem_data  <= {DW{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         addr_r    <= addr_s;
         rem_r     <= rem_s;
         bcnt_r    <= bcnt_s;
         lane_r    <= lane_s;
         shadow_r  <= shadow_s;
         res_ready <= (state_s == S_WAIT);
         mem_req   <= (state_s == S_DRAIN);
         mem_addr  <= addr_s;
         mem_data  <= data_s;
         busy      <= (state_s == S_WAIT) || (state_s == S_DRAIN);
         done      <= (state_s == S_DONE);
      end
   end

endmodule

// File: tb/tb_sa_drain_ctrl.sv
// tb_sa_drain_ctrl: directed + randomized bench for sa_drain_ctrl. A reference
// model expands each job into its expected list of (address, data) writes and
// checks every observed cycle against that list.
module tb_sa_drain_ctrl;
   localparam int LANES = 16;
   localparam int DW    = 16;
   localparam int AW    = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [AW-1:0]        base_addr;
   logic [15:0]          total_convs;
   logic                 res_valid;
   logic [LANES*DW-1:0]  res_data;
   logic                 res_ready;
   logic                 mem_req;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_data;
   logic                 mem_gnt;
   logic                 busy;
   logic                 done;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];

   sa_drain_ctrl #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .total_convs(total_convs), .res_valid(res_valid), .res_data(res_data),
      .res_ready(res_ready), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_gnt(mem_gnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Expected written value for a raw lane value
   function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
      return ($signed(v) < 0) ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [DW-1:0] lane_val(input int mode, input int i);
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (mode == 0) v = 16'h0010 + DW'(i);
      if (mode == 2 && i == 0) v = 16'h8001;
      if (mode == 2 && i == 1) v = 16'h7FFF;
      return v;
   endfunction

   // One full job: start, feed batches on demand, grant writes, check each cycle
   task automatic run_job(input logic [AW-1:0] base, input int total, input int mode,
                          input bit rand_valid, input bit rand_gnt, input int stall_at,
                          output int ready_cycles);
      int pushed = 0;
      int written = 0;
      int stall_left = 0;
      bit stalled = 1'b0;
      bit finished = 1'b0;
      int cyc = 0;
      logic [DW-1:0] lv;
      ready_cycles = 0;
      exp_q.delete();
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      start = 1'b1; base_addr = base; total_convs = 16'(total);
      @(negedge clk);
      start = 1'b0; base_addr = AW'($urandom); total_convs = 16'($urandom);
      while (!finished && cyc < 3000) begin
         if (exp_q.size() != 0) begin
            chk("drain_req", mem_req, 1'b1);
            chk("drain_ready", res_ready, 1'b0);
            chk("drain_busy", busy, 1'b1);
            chk("drain_done", done, 1'b0);
            chk("wr_addr", mem_addr, exp_q[0].a);
            chk("wr_data", mem_data, exp_q[0].d);
         end else if (written < total) begin
            chk("wait_ready", res_ready, 1'b1);
            chk("wait_req", mem_req, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_done", done, 1'b0);
         end else begin
            chk("end_done", done, 1'b1);
            chk("end_busy", busy, 1'b0);
            chk("end_req", mem_req, 1'b0);
            chk("end_ready", res_ready, 1'b0);
            finished = 1'b1;
         end
         if (res_ready) ready_cycles++;
         mem_gnt = 1'b0;
         res_valid = 1'b0;
         for (int i = 0; i < LANES; i++) res_data[i*DW +: DW] = DW'($urandom);
         if (!finished) begin
            if (exp_q.size() != 0) begin
               if (stall_left > 0) begin
                  stall_left--;
               end else if (written == stall_at && !stalled) begin
                  stalled = 1'b1;
                  stall_left = 2;
               end else begin
                  mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
               end
               if (mem_gnt) begin
                  void'(exp_q.pop_front());
                  written++;
               end
               res_valid = 1'($urandom_range(0, 1));
            end else if (written < total) begin
               res_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
               if (res_valid) begin
                  for (int i = 0; i < LANES; i++) begin
                     lv = lane_val(mode, i);
                     res_data[i*DW +: DW] = lv;
                     if (pushed < total) begin
                        exp_q.push_back('{a: base + AW'(pushed), d: ref_out(lv)});
                        pushed++;
                     end
                  end
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!finished) chk("job_timeout", 1'b0, 1'b1);
      mem_gnt = 1'b0;
      res_valid = 1'b0;
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
   endtask

   initial begin
      int rc;
      rst = 1'b1; start = 1'b0; base_addr = 16'h0000; total_convs = 16'd0;
      res_valid = 1'b0; res_data = '0; mem_gnt = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", res_ready, 1'b0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_data", mem_data, 16'h0000);
      rst = 1'b0;

      // Single full batch, grant always high
      run_job(16'h0100, 16, 0, 1'b0, 1'b0, -1, rc);
      chk("one_batch_ready_cycles", rc, 32'd1);

      // Two batches, short tail
      run_job(16'h0000, 20, 0, 1'b0, 1'b0, -1, rc);
      chk("two_batch_ready_cycles", rc, 32'd2);

      // Zero-length job
      run_job(16'h1234, 0, 1, 1'b0, 1'b0, -1, rc);
      chk("zero_ready_cycles", rc, 32'd0);

      // Grant stall on lane 5
      run_job(16'h0300, 16, 1, 1'b0, 1'b0, 5, rc);

      // Address wrap
      run_job(16'hFFFE, 4, 1, 1'b1, 1'b1, -1, rc);

      // Reset in the middle of a drain
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0200; total_convs = 16'd16;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b1;
      for (int i = 0; i < LANES; i++) res_data[i*DW +: DW] = 16'h0010 + DW'(i);
      @(negedge clk);
      res_valid = 1'b0;
      chk("mid_req", mem_req, 1'b1);
      chk("mid_addr0", mem_addr, 16'h0200);
      mem_gnt = 1'b1;
      repeat (7) @(negedge clk);
      chk("mid_addr7", mem_addr, 16'h0207);
      chk("mid_data7", mem_data, ref_out(16'h0017));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_gnt = 1'b0;
      chk("rst_mid_req", mem_req, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_done", done, 1'b0);
      chk("rst_mid_ready", res_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_mid_no_done", done, 1'b0);
      end

      // Normal job after reset, with ReLU corner values in lanes 0 and 1
      run_job(16'h0400, 10, 2, 1'b1, 1'b1, -1, rc);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         run_job(AW'($urandom), $urandom_range(1, 40), $urandom_range(0, 2),
                 1'b1, 1'b1, $urandom_range(0, 12), rc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
